// File: rtl/pixel_port_arbiter.sv
// Arbitrates the VGA framebuffer write port between four drawing clients.
// One client owns the port for a whole burst; round-robin order, hold-time watchdog, off-screen clipping.
module pixel_port_arbiter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int MAX_HOLD = 20000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [3:0]  last,
  input  logic [3:0]  plot_in,
  input  logic [31:0] x_in,
  input  logic [27:0] y_in,
  input  logic [11:0] colour_in,
  output logic [3:0]  gnt,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        preempt,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic [7:0]  clip_cnt
);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_gnt;
  logic [1:0]  r_owner;
  logic        r_busy;
  logic        r_preempt;
  logic [1:0]  r_rr;
  logic [15:0] r_hold;
  logic [7:0]  r_vga_x;
  logic [6:0]  r_vga_y;
  logic [2:0]  r_vga_colour;
  logic        r_vga_plot;
  logic [7:0]  r_clip_cnt;

  logic [1:0]  w_pick_idx;
  logic [1:0]  w_cand;
  logic [7:0]  w_sel_x;
  logic [6:0]  w_sel_y;
  logic [2:0]  w_sel_colour;
  logic        w_own;
  logic        w_req_k;
  logic        w_plot_k;
  logic        w_last_k;
  logic        w_accept;
  logic        w_clip;
  logic        w_rel_a;
  logic        w_rel_b;
  logic        w_rel_c;
  logic        w_release;
  logic        w_preempt;

  // First requester at or after the round-robin pointer: scan offsets high to low so the nearest wins.
  always_comb begin
    w_pick_idx = 2'd0;
    w_cand     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      w_cand = r_rr + 2'(i);
      if (req[w_cand]) w_pick_idx = w_cand;
    end
  end

  always_comb begin
    w_sel_x      = x_in[8*r_owner +: 8];
    w_sel_y      = y_in[7*r_owner +: 7];
    w_sel_colour = colour_in[3*r_owner +: 3];
    w_own        = (r_state == S_OWN);
    w_req_k      = req[r_owner];
    w_plot_k     = plot_in[r_owner];
    w_last_k     = last[r_owner];
    w_accept     = w_own & w_req_k & w_plot_k;
    w_clip       = ({24'd0, w_sel_x} >= 32'(SCREEN_W)) | ({25'd0, w_sel_y} >= 32'(SCREEN_H));
    w_rel_a      = w_own & w_plot_k & w_last_k;
    w_rel_b      = w_own & ~w_req_k;
    w_rel_c      = w_own & (r_hold == 16'(MAX_HOLD - 1));
    w_release    = w_rel_a | w_rel_b | w_rel_c;
    w_preempt    = w_rel_c & ~w_rel_a & ~w_rel_b;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (|req) w_state_nxt = S_OWN;
      S_OWN:   if (w_release) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Grant bookkeeping; the IDLE cycle after every release forces a dead gap between owners.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gnt     <= 4'd0;
      r_owner   <= 2'd0;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
      r_rr      <= 2'd0;
      r_hold    <= 16'd0;
    end else begin
      r_preempt <= w_preempt;
      if (r_state == S_IDLE) begin
        if (|req) begin
          r_gnt   <= 4'd1 << w_pick_idx;
          r_owner <= w_pick_idx;
          r_busy  <= 1'b1;
          r_hold  <= 16'd0;
        end
      end else if (w_release) begin
        r_gnt  <= 4'd0;
        r_busy <= 1'b0;
        r_rr   <= r_owner + 2'd1;
      end else begin
        r_hold <= r_hold + 16'd1;
      end
    end
  end

  // Pixel register: clipped pixels still load coordinates but never strobe the write port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vga_x      <= 8'd0;
      r_vga_y      <= 7'd0;
      r_vga_colour <= 3'd0;
      r_vga_plot   <= 1'b0;
      r_clip_cnt   <= 8'd0;
    end else begin
      r_vga_plot <= 1'b0;
      if (w_accept) begin
        r_vga_x      <= w_sel_x;
        r_vga_y      <= w_sel_y;
        r_vga_colour <= w_sel_colour;
        r_vga_plot   <= ~w_clip;
        if (w_clip && (r_clip_cnt != 8'hFF)) r_clip_cnt <= r_clip_cnt + 8'd1;
      end
    end
  end

  assign gnt        = r_gnt;
  assign owner      = r_owner;
  assign busy       = r_busy;
  assign preempt    = r_preempt;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_vga_plot;
  assign clip_cnt   = r_clip_cnt;

endmodule

// File: tb/tb_pixel_port_arbiter.sv
// Scoreboard bench for pixel_port_arbiter: stimulus queues expected pixels and grants,
// a negedge monitor pops and compares whenever the DUT strobes a pixel or raises a grant.
module tb_pixel_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req, last, plot_in;
  logic [31:0] x_in;
  logic [27:0] y_in;
  logic [11:0] colour_in;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy, preempt, vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic [7:0]  clip_cnt;

  always #5 clk = ~clk;

  pixel_port_arbiter #(.SCREEN_W(160), .SCREEN_H(120), .MAX_HOLD(8)) dut (
    .clk(clk), .resetn(resetn), .req(req), .last(last), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .gnt(gnt), .owner(owner), .busy(busy), .preempt(preempt),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .clip_cnt(clip_cnt)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  int         checks = 0;
  int         errors = 0;
  pix_t       exp_pix[$];
  logic [3:0] exp_gnt[$];
  logic [3:0] prev_gnt = 4'd0;
  pix_t       e_pix;
  logic [3:0] e_gnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (vga_plot) begin
        if (exp_pix.size() == 0) check("unexpected_pixel", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
        else begin
          e_pix = exp_pix.pop_front();
          check("pixel_xyc", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, e_pix});
        end
      end
      if ((gnt != prev_gnt) && (gnt != 4'd0)) begin
        check("grant_gap", {28'd0, prev_gnt}, 32'd0);
        if (exp_gnt.size() == 0) check("unexpected_grant", {28'd0, gnt}, 32'd0);
        else begin
          e_gnt = exp_gnt.pop_front();
          check("grant_order", {28'd0, gnt}, {28'd0, e_gnt});
        end
      end
    end
    prev_gnt = gnt;
  end

  task automatic send_pix(input int k, input logic [7:0] x, input logic [6:0] y,
                          input logic [2:0] c, input logic lst, input logic expect_plot);
    plot_in[k]          = 1'b1;
    last[k]             = lst;
    x_in[8*k +: 8]      = x;
    y_in[7*k +: 7]      = y;
    colour_in[3*k +: 3] = c;
    if (expect_plot) exp_pix.push_back({x, y, c});
    @(negedge clk);
    plot_in[k] = 1'b0;
    last[k]    = 1'b0;
  endtask

  task automatic wait_gnt(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[k] && n < 40);
    check($sformatf("wait_gnt%0d", k), {31'd0, gnt[k]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int order[5];
    order = '{2, 3, 0, 1, 2};
    resetn = 1'b0; req = 4'd0; last = 4'd0; plot_in = 4'd0;
    x_in = 32'd0; y_in = 28'd0; colour_in = 12'd0;
    #1;
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_owner", {30'd0, owner}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_vga_plot", {31'd0, vga_plot}, 32'd0);
    check("rst_clip_cnt", {24'd0, clip_cnt}, 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Single client 1: grant one cycle after request, three pixels, release
    exp_gnt.push_back(4'b0010);
    req[1] = 1'b1;
    @(negedge clk);
    check("t1_gnt_latency", {28'd0, gnt}, 32'b0010);
    check("t1_owner", {30'd0, owner}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    send_pix(1, 8'd10, 7'd20, 3'd2, 1'b0, 1'b1);
    send_pix(1, 8'd11, 7'd20, 3'd2, 1'b0, 1'b1);
    send_pix(1, 8'd12, 7'd20, 3'd2, 1'b1, 1'b1);
    req[1] = 1'b0;
    check("t1_gnt_released", {28'd0, gnt}, 32'd0);
    check("t1_busy_released", {31'd0, busy}, 32'd0);
    check("t1_owner_kept", {30'd0, owner}, 32'd1);
    check("t1_final_plot", {31'd0, vga_plot}, 32'd1);
    check("t1_final_x", {24'd0, vga_x}, 32'd12);
    @(negedge clk);
    check("t1_plot_idle", {31'd0, vga_plot}, 32'd0);
    repeat (2) @(negedge clk);

    // Round robin with all four requesting; pointer is 2 after client 1's burst
    foreach (order[i]) exp_gnt.push_back(4'd1 << order[i]);
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(order[i]);
      send_pix(order[i], 8'(20*order[i]), 7'(order[i] + 1), 3'(order[i] + 1), 1'b0, 1'b1);
      send_pix(order[i], 8'(20*order[i] + 1), 7'(order[i] + 1), 3'(order[i] + 1), 1'b1, 1'b1);
      check("rr_dead_gap", {28'd0, gnt}, 32'd0);
    end
    req = 4'd0;
    repeat (2) @(negedge clk);

    // Clipping on client 0
    exp_gnt.push_back(4'b0001);
    req[0] = 1'b1;
    wait_gnt(0);
    send_pix(0, 8'd160, 7'd5, 3'd5, 1'b0, 1'b0);
    check("clip_x_plot", {31'd0, vga_plot}, 32'd0);
    check("clip_x_reg", {24'd0, vga_x}, 32'd160);
    check("clip_cnt1", {24'd0, clip_cnt}, 32'd1);
    send_pix(0, 8'd5, 7'd120, 3'd5, 1'b0, 1'b0);
    check("clip_y_plot", {31'd0, vga_plot}, 32'd0);
    check("clip_y_reg", {25'd0, vga_y}, 32'd120);
    send_pix(0, 8'd159, 7'd119, 3'd5, 1'b1, 1'b1);
    req[0] = 1'b0;
    check("clip_edge_plot", {31'd0, vga_plot}, 32'd1);
    check("clip_cnt2", {24'd0, clip_cnt}, 32'd2);
    repeat (2) @(negedge clk);

    // Watchdog: client 2 never asserts last, client 3 waits
    exp_gnt.push_back(4'b0100);
    exp_gnt.push_back(4'b1000);
    req = 4'b1100;
    wait_gnt(2);
    for (int i = 0; i < 8; i++) begin
      send_pix(2, 8'(50 + i), 7'd7, 3'd6, 1'b0, 1'b1);
      if (i < 7) check("wd_no_early_preempt", {31'd0, preempt}, 32'd0);
    end
    req[2] = 1'b0;
    check("wd_preempt", {31'd0, preempt}, 32'd1);
    check("wd_gnt_drop", {28'd0, gnt}, 32'd0);
    @(negedge clk);
    check("wd_preempt_pulse", {31'd0, preempt}, 32'd0);
    check("wd_next_gnt", {28'd0, gnt}, 32'b1000);
    send_pix(3, 8'd70, 7'd8, 3'd7, 1'b1, 1'b1);
    req[3] = 1'b0;
    repeat (2) @(negedge clk);

    // Abort: client 0 drops req with plot_in high
    exp_gnt.push_back(4'b0001);
    req[0] = 1'b1;
    wait_gnt(0);
    send_pix(0, 8'd30, 7'd30, 3'd1, 1'b0, 1'b1);
    req[0] = 1'b0;
    send_pix(0, 8'd99, 7'd31, 3'd1, 1'b0, 1'b0);
    check("abort_plot", {31'd0, vga_plot}, 32'd0);
    check("abort_x_held", {24'd0, vga_x}, 32'd30);
    check("abort_gnt", {28'd0, gnt}, 32'd0);
    check("abort_no_preempt", {31'd0, preempt}, 32'd0);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-burst of client 1
    exp_gnt.push_back(4'b0010);
    req[1] = 1'b1;
    wait_gnt(1);
    send_pix(1, 8'd40, 7'd41, 3'd3, 1'b0, 1'b1);
    plot_in[1] = 1'b1;
    x_in[15:8] = 8'd42;
    #2;
    resetn = 1'b0;
    #1;
    check("arst_gnt", {28'd0, gnt}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_owner", {30'd0, owner}, 32'd0);
    check("arst_vga", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
    check("arst_plot", {31'd0, vga_plot}, 32'd0);
    check("arst_clip_cnt", {24'd0, clip_cnt}, 32'd0);
    plot_in = 4'd0;
    req = 4'd0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Simultaneous: client 3 finishes while 0 and 3 request; 0 goes first, then 3
    exp_gnt.push_back(4'b1000);
    exp_gnt.push_back(4'b0001);
    exp_gnt.push_back(4'b1000);
    req = 4'b1000;
    wait_gnt(3);
    send_pix(3, 8'd1, 7'd1, 3'd4, 1'b0, 1'b1);
    req[0] = 1'b1;
    send_pix(3, 8'd2, 7'd1, 3'd4, 1'b1, 1'b1);
    check("sim_dead_gap", {28'd0, gnt}, 32'd0);
    wait_gnt(0);
    check("sim_owner0", {30'd0, owner}, 32'd0);
    send_pix(0, 8'd3, 7'd2, 3'd5, 1'b1, 1'b1);
    req[0] = 1'b0;
    wait_gnt(3);
    send_pix(3, 8'd4, 7'd2, 3'd4, 1'b1, 1'b1);
    req = 4'd0;
    repeat (3) @(negedge clk);

    check("pixels_outstanding", exp_pix.size(), 32'd0);
    check("grants_outstanding", exp_gnt.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
